// File: rtl/rwl_read_seq_if.sv
// ---------------------------------------------------------------------------
// rwl_read_seq_if
// Request/response handshake bundle between the macro read-port logic and
// the read-wordline sequencer.
//
//   req_valid  read request valid            (master -> slave)
//   req_ready  sequencer can take a request  (slave  -> master)
//   req_addr   row to read, AW bits          (master -> slave)
//   rsp_valid  response valid                (slave  -> master)
//   rsp_ready  response consumer ready       (master -> slave)
//   rsp_data   captured read word, DW bits   (slave  -> master)
//   rsp_addr   row the response belongs to   (slave  -> master)
//   rsp_err    requested row was out of range(slave  -> master)
// ---------------------------------------------------------------------------
interface rwl_read_seq_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;

  // Read-port logic side: issues requests, consumes responses.
  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  // Sequencer side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/rwl_read_seq.sv
// ---------------------------------------------------------------------------
// rwl_read_seq
// Read-wordline sequencer for the standard-cell memory array. One read at a
// time: precharge the read bitlines, drive a single registered one-hot read
// wordline for WL_CYC cycles, capture the bitline word and hand it back on
// the response port.
//
// Parameters
//   ROWS     number of read wordlines (width of rwl), ROWS <= 2**AW
//   AW       address width
//   DW       read data width (number of read bitlines)
//   PRE_CYC  bitline precharge cycles per read, 1..255
//   WL_CYC   wordline-high cycles per read, 1..255
//
// Ports
//   clk      clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   bus      request/response handshake (slave modport)
//   rbl_pre  read-bitline precharge enable, registered
//   rwl      one-hot read wordlines, registered, to the buffer strip
//   rbl      read-bitline data from the array
// ---------------------------------------------------------------------------
module rwl_read_seq #(
  parameter int ROWS    = 16,
  parameter int AW      = 4,
  parameter int DW      = 16,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  rwl_read_seq_if.slave    bus,
  output logic             rbl_pre,
  output logic [ROWS-1:0]  rwl,
  input  logic [DW-1:0]    rbl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    WL   = 2'd2,
    RSP  = 2'd3
  } state_t;

  // Counter reload values; the counter runs down to zero, so a phase of
  // N cycles loads N-1.
  localparam logic [7:0] PRE_LOAD = 8'(PRE_CYC - 1);
  localparam logic [7:0] WL_LOAD  = 8'(WL_CYC - 1);

  state_t          state, state_n;
  logic [7:0]      cnt, cnt_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic            in_range_q, in_range_n;
  logic            rbl_pre_n;
  logic [ROWS-1:0] rwl_n;
  logic            rsp_valid_q, rsp_valid_n;
  logic [DW-1:0]   rsp_data_q, rsp_data_n;
  logic [AW-1:0]   rsp_addr_q, rsp_addr_n;
  logic            rsp_err_q, rsp_err_n;

  logic            cnt_zero;
  logic            rsp_done;
  logic            accept;
  logic            req_in_range;
  logic [ROWS-1:0] onehot;

  assign cnt_zero = (cnt == 8'd0);
  assign rsp_done = (state == RSP) && bus.rsp_ready;

  // Ready in IDLE, and also in RSP on the cycle the response is consumed so
  // a new read can start on the handshake edge itself. That keeps
  // back-to-back reads at PRE_CYC + WL_CYC + 1 cycles.
  assign bus.req_ready = (state == IDLE) || rsp_done;
  assign accept        = bus.req_valid && bus.req_ready;

  // Out-of-range rows still run full timing but never raise a wordline.
  assign req_in_range = (32'(bus.req_addr) < ROWS);
  assign onehot       = in_range_q ? (ROWS'(1) << addr_q) : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;

  // State and all registered outputs. Reset is asynchronous so the wordline
  // and precharge drop the instant rst_n falls, even mid-read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      addr_q      <= '0;
      in_range_q  <= 1'b0;
      rbl_pre     <= 1'b0;
      rwl         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      addr_q      <= addr_n;
      in_range_q  <= in_range_n;
      rbl_pre     <= rbl_pre_n;
      rwl         <= rwl_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rsp_addr_q  <= rsp_addr_n;
      rsp_err_q   <= rsp_err_n;
    end
  end

  // Next-state logic: precharge, wordline and response phases in order;
  // a response handshake may chain straight into the next precharge.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept)   state_n = PRE;
      PRE:  if (cnt_zero) state_n = WL;
      WL:   if (cnt_zero) state_n = RSP;
      RSP:  if (rsp_done) state_n = accept ? PRE : IDLE;
      default:            state_n = IDLE;
    endcase
  end

  // Next values of the counter and registered outputs. Everything holds by
  // default, which keeps rwl and the response fields stable between the
  // phase edges that are allowed to change them.
  always_comb begin
    cnt_n       = cnt;
    addr_n      = addr_q;
    in_range_n  = in_range_q;
    rbl_pre_n   = rbl_pre;
    rwl_n       = rwl;
    rsp_valid_n = rsp_valid_q;
    rsp_data_n  = rsp_data_q;
    rsp_addr_n  = rsp_addr_q;
    rsp_err_n   = rsp_err_q;

    case (state)
      IDLE: begin
        if (accept) begin
          addr_n     = bus.req_addr;
          in_range_n = req_in_range;
          cnt_n      = PRE_LOAD;
          rbl_pre_n  = 1'b1;
        end
      end

      PRE: begin
        if (cnt_zero) begin
          rbl_pre_n = 1'b0;
          rwl_n     = onehot;
          cnt_n     = WL_LOAD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end

      WL: begin
        if (cnt_zero) begin
          rwl_n       = '0;
          rsp_valid_n = 1'b1;
          rsp_data_n  = in_range_q ? rbl : '0;
          rsp_addr_n  = addr_q;
          rsp_err_n   = !in_range_q;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end

      RSP: begin
        if (rsp_done) begin
          rsp_valid_n = 1'b0;
          if (accept) begin
            addr_n     = bus.req_addr;
            in_range_n = req_in_range;
            cnt_n      = PRE_LOAD;
            rbl_pre_n  = 1'b1;
          end
        end
      end

      default: begin
        cnt_n = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_rwl_read_seq.sv
// ---------------------------------------------------------------------------
// tb_rwl_read_seq
// Three sequencers with different configurations side by side:
//   instance 0: ROWS=16, PRE_CYC=1, WL_CYC=2 (defaults)
//   instance 1: ROWS=16, PRE_CYC=3, WL_CYC=5
//   instance 2: ROWS=12, PRE_CYC=1, WL_CYC=2
// Each read is modelled as a transaction with an age in cycles since its
// accept edge; the expected pins follow from that age and the configuration.
// ---------------------------------------------------------------------------
module tb_rwl_read_seq;

  localparam int NI = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Bench-side drive and observe vectors, one slot per instance.
  logic [NI-1:0]          req_valid;
  logic [NI-1:0][AW-1:0]  req_addr;
  logic [NI-1:0]          rsp_ready;
  logic [NI-1:0][DW-1:0]  rbl;
  logic [NI-1:0]          req_ready;
  logic [NI-1:0]          rsp_valid;
  logic [NI-1:0][DW-1:0]  rsp_data;
  logic [NI-1:0][AW-1:0]  rsp_addr;
  logic [NI-1:0]          rsp_err;
  logic [NI-1:0]          rbl_pre;
  logic [NI-1:0][15:0]    rwl;

  logic        rbl_pre0, rbl_pre1, rbl_pre2;
  logic [15:0] rwl0, rwl1;
  logic [11:0] rwl2;

  rwl_read_seq_if #(.AW(AW), .DW(DW)) bus0 ();
  rwl_read_seq_if #(.AW(AW), .DW(DW)) bus1 ();
  rwl_read_seq_if #(.AW(AW), .DW(DW)) bus2 ();

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign bus1.req_valid = req_valid[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.rsp_ready = rsp_ready[1];
  assign bus2.req_valid = req_valid[2];
  assign bus2.req_addr  = req_addr[2];
  assign bus2.rsp_ready = rsp_ready[2];

  assign req_ready = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
  assign rsp_valid = {bus2.rsp_valid, bus1.rsp_valid, bus0.rsp_valid};
  assign rsp_data  = {bus2.rsp_data,  bus1.rsp_data,  bus0.rsp_data};
  assign rsp_addr  = {bus2.rsp_addr,  bus1.rsp_addr,  bus0.rsp_addr};
  assign rsp_err   = {bus2.rsp_err,   bus1.rsp_err,   bus0.rsp_err};
  assign rbl_pre   = {rbl_pre2, rbl_pre1, rbl_pre0};
  assign rwl       = {{4'b0000, rwl2}, rwl1, rwl0};

  rwl_read_seq #(.ROWS(16), .AW(AW), .DW(DW), .PRE_CYC(1), .WL_CYC(2)) u_dflt (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .rbl_pre(rbl_pre0), .rwl(rwl0), .rbl(rbl[0])
  );

  rwl_read_seq #(.ROWS(16), .AW(AW), .DW(DW), .PRE_CYC(3), .WL_CYC(5)) u_slow (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .rbl_pre(rbl_pre1), .rwl(rwl1), .rbl(rbl[1])
  );

  rwl_read_seq #(.ROWS(12), .AW(AW), .DW(DW), .PRE_CYC(1), .WL_CYC(2)) u_r12 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .rbl_pre(rbl_pre2), .rwl(rwl2), .rbl(rbl[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per instance, one read in flight (busy, with its age
  // in cycles since acceptance) or one response waiting to be taken.
  int           m_p    [NI];
  int           m_w    [NI];
  int           m_rows [NI];
  bit           m_busy [NI];
  bit           m_pend [NI];
  bit           m_acc  [NI];
  int           m_age  [NI];
  logic [AW-1:0] m_addr [NI];
  logic [DW-1:0] m_data [NI];
  logic [AW-1:0] m_raddr[NI];
  bit           m_err  [NI];

  task automatic checkOutput(input string tag, input int k,
                             input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s[%0d]: observed 'h%0h, expected 'h%0h", tag, k, observed, expected);
    end
  endtask

  // Drive one instance's inputs; called on the falling edge.
  task automatic applyStimulus(input int k, input logic v, input logic [AW-1:0] a,
                               input logic rr, input logic [DW-1:0] d);
    req_valid[k] = v;
    req_addr[k]  = a;
    rsp_ready[k] = rr;
    rbl[k]       = d;
  endtask

  task automatic modelClear();
    for (int k = 0; k < NI; k++) begin
      m_busy[k]  = 1'b0;
      m_pend[k]  = 1'b0;
      m_acc[k]   = 1'b0;
      m_age[k]   = 0;
      m_addr[k]  = '0;
      m_data[k]  = '0;
      m_raddr[k] = '0;
      m_err[k]   = 1'b0;
    end
  endtask

  // Advance one instance's model across a rising edge using the inputs
  // that are stable at that edge.
  task automatic modelEdge(input int k);
    bit can_take;
    bit in_range;
    m_acc[k] = 1'b0;
    if (m_busy[k]) begin
      m_age[k]++;
      if (m_age[k] == m_p[k] + m_w[k]) begin
        in_range   = int'(m_addr[k]) < m_rows[k];
        m_busy[k]  = 1'b0;
        m_pend[k]  = 1'b1;
        m_data[k]  = in_range ? rbl[k] : '0;
        m_raddr[k] = m_addr[k];
        m_err[k]   = !in_range;
      end
    end else begin
      can_take = !m_pend[k] || rsp_ready[k];
      if (m_pend[k] && rsp_ready[k]) m_pend[k] = 1'b0;
      if (can_take && req_valid[k]) begin
        m_busy[k] = 1'b1;
        m_age[k]  = 0;
        m_addr[k] = req_addr[k];
        m_acc[k]  = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] expRwl(input int k);
    if (m_busy[k] && m_age[k] >= m_p[k] && int'(m_addr[k]) < m_rows[k])
      return 16'(1) << m_addr[k];
    return 16'h0000;
  endfunction

  task automatic checkAll(input int k);
    bit exp_ready;
    bit exp_pre;
    exp_ready = (!m_busy[k] && !m_pend[k]) || (m_pend[k] && rsp_ready[k]);
    exp_pre   = m_busy[k] && (m_age[k] < m_p[k]);
    checkOutput("req_ready", k, 32'(req_ready[k]), 32'(exp_ready));
    checkOutput("rbl_pre",   k, 32'(rbl_pre[k]),   32'(exp_pre));
    checkOutput("rwl",       k, 32'(rwl[k]),       32'(expRwl(k)));
    checkOutput("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_pend[k]));
    if (m_pend[k]) begin
      checkOutput("rsp_data", k, 32'(rsp_data[k]), 32'(m_data[k]));
      checkOutput("rsp_addr", k, 32'(rsp_addr[k]), 32'(m_raddr[k]));
      checkOutput("rsp_err",  k, 32'(rsp_err[k]),  32'(m_err[k]));
    end
  endtask

  // One clock: model follows the rising edge, pins are compared on the
  // falling edge, and the caller then drives new inputs.
  task automatic tick();
    @(posedge clk);
    if (rst_n) for (int k = 0; k < NI; k++) modelEdge(k);
    @(negedge clk);
    for (int k = 0; k < NI; k++) checkAll(k);
  endtask

  initial begin
    int a;
    int hs;
    int pre_cnt;
    int wl_cnt;
    int lat;
    bit rwl_seen;

    m_p[0] = 1; m_w[0] = 2; m_rows[0] = 16;
    m_p[1] = 3; m_w[1] = 5; m_rows[1] = 16;
    m_p[2] = 1; m_w[2] = 2; m_rows[2] = 12;
    modelClear();
    for (int k = 0; k < NI; k++) applyStimulus(k, 1'b0, '0, 1'b0, '0);

    // Reset state on every instance.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      checkOutput("rst_req_ready", k, 32'(req_ready[k]), 32'd1);
      checkOutput("rst_rbl_pre",   k, 32'(rbl_pre[k]),   32'd0);
      checkOutput("rst_rwl",       k, 32'(rwl[k]),       32'd0);
      checkOutput("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      checkOutput("rst_rsp_data",  k, 32'(rsp_data[k]),  32'd0);
      checkOutput("rst_rsp_addr",  k, 32'(rsp_addr[k]),  32'd0);
      checkOutput("rst_rsp_err",   k, 32'(rsp_err[k]),   32'd0);
    end
    @(negedge clk);

    // Single read, row 5, defaults: precharge, two wordline cycles, response.
    applyStimulus(0, 1'b1, 4'd5, 1'b0, 16'hA5C3);
    tick();
    checkOutput("t1_pre", 0, 32'(rbl_pre[0]), 32'd1);
    applyStimulus(0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 16'hA5C3);
    tick();
    checkOutput("t1_rwl_a", 0, 32'(rwl[0]), 32'h0020);
    tick();
    checkOutput("t1_rwl_b", 0, 32'(rwl[0]), 32'h0020);
    tick();
    checkOutput("t1_valid", 0, 32'(rsp_valid[0]), 32'd1);
    checkOutput("t1_data",  0, 32'(rsp_data[0]),  32'hA5C3);
    checkOutput("t1_addr",  0, 32'(rsp_addr[0]),  32'd5);
    checkOutput("t1_err",   0, 32'(rsp_err[0]),   32'd0);
    applyStimulus(0, 1'b0, '0, 1'b1, 16'($urandom));
    tick();

    // Back-to-back sweep of every row: one response every 4 cycles, in order.
    a  = 0;
    hs = 0;
    applyStimulus(0, 1'b1, 4'd0, 1'b1, 16'($urandom));
    for (int c = 0; c < 64; c++) begin
      tick();
      if (rsp_valid[0]) begin
        checkOutput("sweep_order", 0, 32'(rsp_addr[0]), 32'(hs));
        hs++;
      end
      if (m_acc[0]) a++;
      applyStimulus(0, a < 16, 4'(a), 1'b1, 16'($urandom));
    end
    checkOutput("sweep_count", 0, 32'(hs), 32'd16);
    applyStimulus(0, 1'b0, '0, 1'b1, 16'($urandom));
    tick();

    // Slow configuration, row 15: 3 precharge, 5 wordline, latency 8.
    pre_cnt = 0;
    wl_cnt  = 0;
    lat     = -1;
    applyStimulus(1, 1'b1, 4'd15, 1'b0, 16'($urandom));
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rbl_pre[1]) pre_cnt++;
      if (rwl[1] == 16'h8000) wl_cnt++;
      if (rsp_valid[1]) begin
        lat = c;
        break;
      end
      applyStimulus(1, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 16'($urandom));
    end
    checkOutput("slow_pre_cycles", 1, 32'(pre_cnt), 32'd3);
    checkOutput("slow_wl_cycles",  1, 32'(wl_cnt),  32'd5);
    checkOutput("slow_latency",    1, 32'(lat),     32'd8);
    applyStimulus(1, 1'b0, '0, 1'b1, 16'($urandom));
    tick();

    // Response stalled 10 cycles with a request held pending.
    applyStimulus(0, 1'b1, 4'd9, 1'b0, 16'($urandom));
    tick();
    applyStimulus(0, 1'b1, 4'd3, 1'b0, 16'($urandom));
    repeat (3) tick();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 1'b1, 4'd3, 1'b0, 16'($urandom));
      tick();
      checkOutput("stall_ready", 0, 32'(req_ready[0]), 32'd0);
      checkOutput("stall_addr",  0, 32'(rsp_addr[0]),  32'd9);
      checkOutput("stall_rwl",   0, 32'(rwl[0]),       32'd0);
    end
    applyStimulus(0, 1'b1, 4'd3, 1'b1, 16'($urandom));
    #1;
    checkOutput("release_ready", 0, 32'(req_ready[0]), 32'd1);
    tick();
    checkOutput("release_accept", 0, 32'(rbl_pre[0]),   32'd1);
    checkOutput("release_rsp",    0, 32'(rsp_valid[0]), 32'd0);
    applyStimulus(0, 1'b0, '0, 1'b1, 16'($urandom));
    repeat (4) tick();

    // Reset pulsed while the wordline is up: outputs drop without a clock.
    applyStimulus(0, 1'b1, 4'd7, 1'b0, 16'($urandom));
    tick();
    applyStimulus(0, 1'b0, '0, 1'b0, 16'($urandom));
    tick();
    checkOutput("mid_rwl_up", 0, 32'(rwl[0]), 32'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rwl",   0, 32'(rwl[0]),       32'd0);
    checkOutput("async_pre",   0, 32'(rbl_pre[0]),   32'd0);
    checkOutput("async_valid", 0, 32'(rsp_valid[0]), 32'd0);
    modelClear();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, '0, 1'b1, 16'($urandom));
    #1;
    checkOutput("post_rst_ready", 0, 32'(req_ready[0]), 32'd1);
    repeat (5) tick();

    // ROWS=12 instance, row 13: no wordline, error response, same latency.
    rwl_seen = 1'b0;
    lat      = -1;
    applyStimulus(2, 1'b1, 4'd13, 1'b0, 16'hFFFF);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rwl[2] != 16'h0000) rwl_seen = 1'b1;
      if (rsp_valid[2]) begin
        lat = c;
        break;
      end
      applyStimulus(2, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 16'hFFFF);
    end
    checkOutput("oor_rwl_seen", 2, 32'(rwl_seen),   32'd0);
    checkOutput("oor_latency",  2, 32'(lat),        32'd3);
    checkOutput("oor_err",      2, 32'(rsp_err[2]), 32'd1);
    checkOutput("oor_data",     2, 32'(rsp_data[2]), 32'd0);
    checkOutput("oor_addr",     2, 32'(rsp_addr[2]), 32'd13);
    applyStimulus(2, 1'b0, '0, 1'b1, 16'($urandom));
    tick();

    // Randomised traffic on all three instances against the model.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NI; k++) begin
        applyStimulus(k, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 1) == 1, 16'($urandom));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
